// File: rtl/reg_writeback_arb_pkg.sv
// reg_writeback_arb_pkg: shared widths, request types and source encoding for the write-back arbiter
package reg_writeback_arb_pkg;
  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int DEFAULT_REG_WIDTH = 32;
  typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEFAULT_REG_WIDTH-1:0] reg_val_t;
  typedef struct packed {
    reg_addr_t addr;
    reg_val_t val;
  } wb_req_t;
  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_t;
endpackage

// File: rtl/reg_writeback_arb_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, the source not granted last wins a tie
module rr_arb2
  import reg_writeback_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);
  src_t last;
  assign o_gnt[0] = i_req[0] & (~i_req[1] | (last == SRC_B));
  assign o_gnt[1] = i_req[1] & (~i_req[0] | (last == SRC_A));
  // pointer remembers the most recent winner; starting at B lets A win the first tie
  always_ff @(posedge i_clk) begin
    if (i_rst) last <= SRC_B;
    else if (|o_gnt) last <= o_gnt[1] ? SRC_B : SRC_A;
  end
endmodule

// File: rtl/reg_writeback_arb.sv
// reg_writeback_arb: arbitrates two result producers onto the reg_file write port and tracks pending writes
module reg_writeback_arb
  import reg_writeback_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int REG_WIDTH  = DEFAULT_REG_WIDTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_a_valid,
  output logic                       o_a_ready,
  input  logic [ADDR_WIDTH-1:0]      i_a_addr,
  input  logic [REG_WIDTH-1:0]       i_a_val,
  input  logic                       i_b_valid,
  output logic                       o_b_ready,
  input  logic [ADDR_WIDTH-1:0]      i_b_addr,
  input  logic [REG_WIDTH-1:0]       i_b_val,
  input  logic                       i_issue_en,
  input  logic [ADDR_WIDTH-1:0]      i_issue_addr,
  output logic [(1<<ADDR_WIDTH)-1:0] o_pending,
  output logic [ADDR_WIDTH-1:0]      o_reg_addr_w,
  output logic [REG_WIDTH-1:0]       o_reg_val_w,
  output logic                       o_write_en,
  output logic                       o_waw_err,
  output logic                       o_spur_err
);
  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [NUM_REGS-1:0] ONE = 1;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]  val;
  } req_t;
  logic [1:0] gnt;
  logic any_gnt;
  req_t sel;
  logic [NUM_REGS-1:0] set_mask, clr_mask;
  rr_arb2 u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_req ({i_b_valid & ~i_rst, i_a_valid & ~i_rst}),
    .o_gnt (gnt)
  );
  assign o_a_ready = gnt[0];
  assign o_b_ready = gnt[1];
  // winning request and the scoreboard bits it touches this cycle
  always_comb begin
    any_gnt = |gnt;
    sel = gnt[1] ? req_t'{addr: i_b_addr, val: i_b_val} : req_t'{addr: i_a_addr, val: i_a_val};
    set_mask = i_issue_en ? ONE << i_issue_addr : '0;
    clr_mask = any_gnt ? ONE << sel.addr : '0;
  end
  // output stage drains every cycle; addr/val hold when idle, reset drops any in-flight write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_write_en <= 1'b0;
      o_reg_addr_w <= '0;
      o_reg_val_w <= '0;
    end else begin
      o_write_en <= any_gnt;
      if (any_gnt) begin
        o_reg_addr_w <= sel.addr;
        o_reg_val_w <= sel.val;
      end
    end
  end
  // scoreboard with set winning over a same-edge clear, plus registered error pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pending <= '0;
      o_waw_err <= 1'b0;
      o_spur_err <= 1'b0;
    end else begin
      o_pending <= (o_pending & ~clr_mask) | set_mask;
      o_waw_err <= i_issue_en && o_pending[i_issue_addr] && !clr_mask[i_issue_addr];
      o_spur_err <= any_gnt && !o_pending[sel.addr];
    end
  end
endmodule

// File: tb/tb_reg_writeback_arb.sv
// tb_reg_writeback_arb: directed checks of arbitration, output stage, scoreboard and error pulses
module tb_reg_writeback_arb;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_a_valid = 1'b0, i_b_valid = 1'b0, i_issue_en = 1'b0;
  logic o_a_ready, o_b_ready, o_write_en, o_waw_err, o_spur_err;
  logic [2:0] i_a_addr = '0, i_b_addr = '0, i_issue_addr = '0, o_reg_addr_w;
  logic [31:0] i_a_val = '0, i_b_val = '0, o_reg_val_w;
  logic [7:0] o_pending;
  logic [31:0] regs [8] = '{default: 32'h0};
  int tests = 0;
  int failed = 0;

  always #5 i_clk = ~i_clk;

  reg_writeback_arb dut (
    .i_clk (i_clk), .i_rst (i_rst),
    .i_a_valid (i_a_valid), .o_a_ready (o_a_ready), .i_a_addr (i_a_addr), .i_a_val (i_a_val),
    .i_b_valid (i_b_valid), .o_b_ready (o_b_ready), .i_b_addr (i_b_addr), .i_b_val (i_b_val),
    .i_issue_en (i_issue_en), .i_issue_addr (i_issue_addr), .o_pending (o_pending),
    .o_reg_addr_w (o_reg_addr_w), .o_reg_val_w (o_reg_val_w), .o_write_en (o_write_en),
    .o_waw_err (o_waw_err), .o_spur_err (o_spur_err)
  );

  always @(posedge i_clk) if (o_write_en) regs[o_reg_addr_w] <= o_reg_val_w;

  function automatic logic [31:0] rd(input logic [2:0] a);
    return (o_write_en && o_reg_addr_w == a) ? o_reg_val_w : regs[a];
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_a_valid = 1'b0;
    i_b_valid = 1'b0;
    i_issue_en = 1'b0;
    step();
    step();
    i_rst = 1'b0;
  endtask

  task automatic issue(input logic [2:0] a);
    i_issue_en = 1'b1;
    i_issue_addr = a;
    step();
    i_issue_en = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_a_valid = 1'b1;
    i_b_valid = 1'b1;
    step();
    step();
    tests++; if (o_a_ready !== 1'b0 || o_b_ready !== 1'b0) begin failed++; $display("FAIL reset_ready: a=%b b=%b want 0 0", o_a_ready, o_b_ready); end
    i_a_valid = 1'b0;
    i_b_valid = 1'b0;
    step();
    i_rst = 1'b0;
    #1;
    tests++; if (o_write_en !== 1'b0) begin failed++; $display("FAIL reset_we: got %b want 0", o_write_en); end
    tests++; if (o_reg_addr_w !== 3'd0 || o_reg_val_w !== 32'h0) begin failed++; $display("FAIL reset_addr_val: got %h/%h want 0/0", o_reg_addr_w, o_reg_val_w); end
    tests++; if (o_pending !== 8'h00) begin failed++; $display("FAIL reset_pending: got %h want 00", o_pending); end
    tests++; if (o_waw_err !== 1'b0 || o_spur_err !== 1'b0) begin failed++; $display("FAIL reset_err: got %b%b want 00", o_waw_err, o_spur_err); end
  endtask

  task automatic test_a_only();
    do_reset();
    issue(3'd3);
    tests++; if (o_pending !== 8'h08) begin failed++; $display("FAIL a_only_pend_set: got %h want 08", o_pending); end
    i_a_valid = 1'b1;
    i_a_addr = 3'd3;
    i_a_val = 32'hDEAD_BEEF;
    #1;
    tests++; if (o_a_ready !== 1'b1 || o_b_ready !== 1'b0) begin failed++; $display("FAIL a_only_ready: a=%b b=%b want 1 0", o_a_ready, o_b_ready); end
    tests++; if (o_write_en !== 1'b0) begin failed++; $display("FAIL a_only_latency: we=%b want 0", o_write_en); end
    step();
    i_a_valid = 1'b0;
    tests++; if (o_write_en !== 1'b1 || o_reg_addr_w !== 3'd3 || o_reg_val_w !== 32'hDEAD_BEEF) begin failed++; $display("FAIL a_only_write: got %b %h %h want 1 3 deadbeef", o_write_en, o_reg_addr_w, o_reg_val_w); end
    tests++; if (rd(3'd3) !== 32'hDEAD_BEEF) begin failed++; $display("FAIL a_only_read: got %h want deadbeef", rd(3'd3)); end
    tests++; if (o_pending !== 8'h00 || o_spur_err !== 1'b0) begin failed++; $display("FAIL a_only_pend_clr: got %h spur=%b want 00 0", o_pending, o_spur_err); end
    step();
    tests++; if (o_write_en !== 1'b0 || o_reg_addr_w !== 3'd3 || o_reg_val_w !== 32'hDEAD_BEEF) begin failed++; $display("FAIL a_only_hold: got %b %h %h want 0 3 deadbeef", o_write_en, o_reg_addr_w, o_reg_val_w); end
    tests++; if (regs[3] !== 32'hDEAD_BEEF) begin failed++; $display("FAIL a_only_regfile: got %h want deadbeef", regs[3]); end
  endtask

  task automatic test_back_to_back();
    logic exp_a;
    do_reset();
    i_a_valid = 1'b1;
    i_b_valid = 1'b1;
    i_a_addr = 3'd1;
    i_b_addr = 3'd2;
    for (int i = 0; i < 4; i++) begin
      i_a_val = 32'h100 + i;
      i_b_val = 32'h200 + i;
      #1;
      exp_a = (i % 2 == 0);
      tests++; if (o_a_ready !== exp_a || o_b_ready !== !exp_a) begin failed++; $display("FAIL b2b_grant%0d: a=%b b=%b want %b %b", i, o_a_ready, o_b_ready, exp_a, !exp_a); end
      step();
      tests++; if (o_write_en !== 1'b1 || o_reg_addr_w !== (exp_a ? 3'd1 : 3'd2) || o_reg_val_w !== (exp_a ? 32'h100 + i : 32'h200 + i)) begin failed++; $display("FAIL b2b_write%0d: got %b %h %h", i, o_write_en, o_reg_addr_w, o_reg_val_w); end
    end
    i_a_valid = 1'b0;
    i_b_valid = 1'b0;
    step();
    tests++; if (o_write_en !== 1'b0) begin failed++; $display("FAIL b2b_idle: we=%b want 0", o_write_en); end
    tests++; if (regs[1] !== 32'h102 || regs[2] !== 32'h203) begin failed++; $display("FAIL b2b_regs: got %h %h want 102 203", regs[1], regs[2]); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    issue(3'd5);
    tests++; if (o_pending !== 8'h20) begin failed++; $display("FAIL sb_set: got %h want 20", o_pending); end
    step();
    tests++; if (o_pending !== 8'h20) begin failed++; $display("FAIL sb_hold: got %h want 20", o_pending); end
    i_b_valid = 1'b1;
    i_b_addr = 3'd5;
    i_b_val = 32'd67;
    #1;
    tests++; if (o_b_ready !== 1'b1 || o_a_ready !== 1'b0) begin failed++; $display("FAIL sb_b_ready: a=%b b=%b want 0 1", o_a_ready, o_b_ready); end
    tests++; if (o_pending !== 8'h20) begin failed++; $display("FAIL sb_pre_grant: got %h want 20", o_pending); end
    step();
    i_b_valid = 1'b0;
    tests++; if (o_pending !== 8'h00 || o_write_en !== 1'b1) begin failed++; $display("FAIL sb_clear: pend=%h we=%b want 00 1", o_pending, o_write_en); end
    tests++; if (rd(3'd5) !== 32'd67) begin failed++; $display("FAIL sb_bypass: got %0d want 67", rd(3'd5)); end
    tests++; if (o_spur_err !== 1'b0 || o_waw_err !== 1'b0) begin failed++; $display("FAIL sb_no_err: got %b%b want 00", o_waw_err, o_spur_err); end
  endtask

  task automatic test_errors();
    do_reset();
    issue(3'd6);
    tests++; if (o_waw_err !== 1'b0) begin failed++; $display("FAIL waw_first: got %b want 0", o_waw_err); end
    issue(3'd6);
    tests++; if (o_waw_err !== 1'b1 || o_pending !== 8'h40) begin failed++; $display("FAIL waw_pulse: err=%b pend=%h want 1 40", o_waw_err, o_pending); end
    step();
    tests++; if (o_waw_err !== 1'b0) begin failed++; $display("FAIL waw_single: got %b want 0", o_waw_err); end
    i_a_valid = 1'b1;
    i_a_addr = 3'd7;
    i_a_val = 32'h7777;
    step();
    i_a_valid = 1'b0;
    tests++; if (o_spur_err !== 1'b1) begin failed++; $display("FAIL spur_pulse: got %b want 1", o_spur_err); end
    tests++; if (o_write_en !== 1'b1 || o_reg_addr_w !== 3'd7 || o_reg_val_w !== 32'h7777) begin failed++; $display("FAIL spur_write: got %b %h %h want 1 7 7777", o_write_en, o_reg_addr_w, o_reg_val_w); end
    step();
    tests++; if (o_spur_err !== 1'b0 || regs[7] !== 32'h7777) begin failed++; $display("FAIL spur_after: err=%b reg7=%h want 0 7777", o_spur_err, regs[7]); end
  endtask

  task automatic test_same_edge();
    do_reset();
    issue(3'd4);
    i_issue_en = 1'b1;
    i_issue_addr = 3'd4;
    i_a_valid = 1'b1;
    i_a_addr = 3'd4;
    i_a_val = 32'h4444;
    step();
    i_issue_en = 1'b0;
    i_a_valid = 1'b0;
    tests++; if (o_pending !== 8'h10) begin failed++; $display("FAIL same_edge_pend: got %h want 10", o_pending); end
    tests++; if (o_waw_err !== 1'b0 || o_spur_err !== 1'b0 || o_write_en !== 1'b1) begin failed++; $display("FAIL same_edge_flags: waw=%b spur=%b we=%b want 0 0 1", o_waw_err, o_spur_err, o_write_en); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] snap [8];
    do_reset();
    for (int r = 0; r < 8; r++) issue(3'(r));
    tests++; if (o_pending !== 8'hFF) begin failed++; $display("FAIL rst_mid_full: got %h want ff", o_pending); end
    for (int r = 0; r < 8; r++) snap[r] = regs[r];
    i_a_valid = 1'b1;
    i_a_addr = 3'd0;
    i_a_val = 32'h5555_AAAA;
    i_rst = 1'b1;
    #1;
    tests++; if (o_a_ready !== 1'b0) begin failed++; $display("FAIL rst_mid_ready: got %b want 0", o_a_ready); end
    step();
    tests++; if (o_write_en !== 1'b0 || o_pending !== 8'h00) begin failed++; $display("FAIL rst_mid_state: we=%b pend=%h want 0 00", o_write_en, o_pending); end
    i_a_valid = 1'b0;
    i_rst = 1'b0;
    step();
    for (int r = 0; r < 8; r++) begin
      tests++; if (regs[r] !== snap[r]) begin failed++; $display("FAIL rst_mid_reg%0d: got %h want %h", r, regs[r], snap[r]); end
    end
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_back_to_back();
    test_scoreboard();
    test_errors();
    test_same_edge();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
